// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared encodings, board geometry and sequencer states for the candy board control
//
// Purpose : action encodings, board size, position field helpers and the
//           sequencer state enum shared by cc_swap_target and cc_action_sequencer.
// Ports   : none (package).
package cc_pkg;

    localparam int BOARD_DIM = 6;
    localparam int POS_W     = 6;
    localparam int COORD_W   = 3;

    // Position layout: [5:3] row, [2:0] col.
    localparam int ROW_LSB = 3;

    typedef enum logic [1:0] {
        ACT_UP    = 2'd0,
        ACT_DOWN  = 2'd1,
        ACT_LEFT  = 2'd2,
        ACT_RIGHT = 2'd3
    } act_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SWAP  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_EVAL  = 3'd4,
        ST_CLEAR = 3'd5,
        ST_DROP  = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    function automatic logic [COORD_W-1:0] pos_row(input logic [POS_W-1:0] pos);
        return pos[POS_W-1:ROW_LSB];
    endfunction

    function automatic logic [COORD_W-1:0] pos_col(input logic [POS_W-1:0] pos);
        return pos[ROW_LSB-1:0];
    endfunction

    function automatic logic [POS_W-1:0] make_pos(input logic [COORD_W-1:0] row,
                                                  input logic [COORD_W-1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/cc_swap_target.sv
// rtl/cc_swap_target.sv - combinational neighbour position and legality of one swap action
//
// Purpose : given an action direction and source position, produce the neighbour
//           cell and whether the swap stays on the 6x6 board.
// Ports   : act_type_i  - direction (Up/Down/Left/Right)
//           act_pos_i   - source position {row, col}
//           nb_pos_o    - neighbour position {row, col}
//           valid_o     - source on board and neighbour on board
module cc_swap_target
    import cc_pkg::*;
(
    input  logic [1:0]       act_type_i,
    input  logic [POS_W-1:0] act_pos_i,
    output logic [POS_W-1:0] nb_pos_o,
    output logic             valid_o
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(BOARD_DIM - 1);

    logic [COORD_W-1:0] row, col, nb_row, nb_col;
    logic               src_ok, edge_ok;

    always_comb begin
        row     = pos_row(act_pos_i);
        col     = pos_col(act_pos_i);
        nb_row  = row;
        nb_col  = col;
        src_ok  = (row <= LAST) && (col <= LAST);
        edge_ok = 1'b0;
        case (act_e'(act_type_i))
            ACT_UP: begin
                edge_ok = (row != '0);
                nb_row  = row - 1'b1;
            end
            ACT_DOWN: begin
                edge_ok = (row < LAST);
                nb_row  = row + 1'b1;
            end
            ACT_LEFT: begin
                edge_ok = (col != '0);
                nb_col  = col - 1'b1;
            end
            default: begin
                edge_ok = (col < LAST);
                nb_col  = col + 1'b1;
            end
        endcase
        nb_pos_o = make_pos(nb_row, nb_col);
        valid_o  = src_ok && edge_ok;
    end

endmodule

// File: rtl/cc_action_sequencer.sv
// rtl/cc_action_sequencer.sv - control FSM stepping the candy board datapath through queued actions
//
// Purpose : per action: swap, scan rows/cols 0..5, clear, gravity drop, repeated
//           while matches remain (bounded cascade). Accumulates a saturating round
//           score and pulses it out when all actions are done.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           start, num_actions  - begin round with the given action count
//           act_rd_addr         - action buffer read index
//           act_type, act_pos   - action at act_rd_addr (combinational read)
//           swap_en/_pos_a/_b   - one-cycle swap command
//           scan_en, scan_idx   - scan strobe and row/column index
//           match_cnt           - matched windows for scan_idx
//           clear_en, drop_en   - one-cycle clear / gravity commands
//           drop_done           - gravity complete
//           busy, out_valid, out_score, err - status and round result
module cc_action_sequencer
    import cc_pkg::*;
#(
    parameter int MAX_ACTIONS  = 10,
    parameter int MAX_CASCADE  = 8,
    parameter int DROP_TIMEOUT = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] num_actions,
    output logic [3:0] act_rd_addr,
    input  logic [1:0] act_type,
    input  logic [5:0] act_pos,
    output logic       swap_en,
    output logic [5:0] swap_pos_a,
    output logic [5:0] swap_pos_b,
    output logic       scan_en,
    output logic [2:0] scan_idx,
    input  logic [3:0] match_cnt,
    output logic       clear_en,
    output logic       drop_en,
    input  logic       drop_done,
    output logic       busy,
    output logic       out_valid,
    output logic [6:0] out_score,
    output logic       err
);

    localparam int TIMER_W = $clog2(DROP_TIMEOUT + 1);
    localparam logic [6:0] SCORE_MAX = 7'd127;

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         count_q, count_d;
    logic [3:0]         pass_q, pass_d;
    logic [5:0]         pass_sum_q, pass_sum_d;
    logic [6:0]         score_q, score_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         scan_idx_q, scan_idx_d;
    logic               err_q, err_d;

    logic [5:0] nb_pos;
    logic       nb_valid;
    logic [3:0] clamped_cnt;
    logic [7:0] score_sum;
    logic       last_action;

    cc_swap_target u_swap_target (
        .act_type_i (act_type),
        .act_pos_i  (act_pos),
        .nb_pos_o   (nb_pos),
        .valid_o    (nb_valid)
    );

    assign clamped_cnt = (num_actions > 4'(MAX_ACTIONS)) ? 4'(MAX_ACTIONS) : num_actions;
    assign last_action = (idx_q == count_q - 4'd1);
    assign score_sum   = {1'b0, score_q} + {2'b00, pass_sum_q};

    assign act_rd_addr = idx_q;
    assign scan_idx    = scan_idx_q;
    assign busy        = (state_q != ST_IDLE);
    assign err         = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            pass_q     <= '0;
            pass_sum_q <= '0;
            score_q    <= '0;
            timer_q    <= '0;
            scan_idx_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            pass_q     <= pass_d;
            pass_sum_q <= pass_sum_d;
            score_q    <= score_d;
            timer_q    <= timer_d;
            scan_idx_q <= scan_idx_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        count_d    = count_q;
        pass_d     = pass_q;
        pass_sum_d = pass_sum_q;
        score_d    = score_q;
        timer_d    = timer_q;
        scan_idx_d = scan_idx_q;
        err_d      = err_q;
        swap_en    = 1'b0;
        swap_pos_a = '0;
        swap_pos_b = '0;
        scan_en    = 1'b0;
        clear_en   = 1'b0;
        drop_en    = 1'b0;
        out_valid  = 1'b0;
        out_score  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d    = clamped_cnt;
                    idx_d      = '0;
                    score_d    = '0;
                    err_d      = 1'b0;
                    pass_d     = '0;
                    pass_sum_d = '0;
                    timer_d    = '0;
                    scan_idx_d = '0;
                    state_d    = (clamped_cnt == 4'd0) ? ST_DONE : ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (nb_valid) begin
                    state_d = ST_SWAP;
                end else if (last_action) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_FETCH;
                end
            end

            ST_SWAP: begin
                swap_en    = 1'b1;
                swap_pos_a = act_pos;
                swap_pos_b = nb_pos;
                pass_d     = 4'd1;
                scan_idx_d = '0;
                state_d    = ST_SCAN;
            end

            ST_SCAN: begin
                scan_en    = 1'b1;
                pass_sum_d = pass_sum_q + {2'b00, match_cnt};
                if (scan_idx_q == 3'(BOARD_DIM - 1)) begin
                    scan_idx_d = '0;
                    state_d    = ST_EVAL;
                end else begin
                    scan_idx_d = scan_idx_q + 3'd1;
                end
            end

            ST_EVAL: begin
                score_d    = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[6:0];
                pass_sum_d = '0;
                if (pass_sum_q != '0) begin
                    state_d = ST_CLEAR;
                end else if (last_action) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_FETCH;
                end
            end

            ST_CLEAR: begin
                clear_en = 1'b1;
                timer_d  = '0;
                state_d  = ST_DROP;
            end

            ST_DROP: begin
                // Timer is zero only on the first DROP cycle, so it doubles as
                // the one-shot marker for the drop command.
                drop_en = (timer_q == '0);
                if (drop_done || (timer_q == TIMER_W'(DROP_TIMEOUT - 1))) begin
                    timer_d = '0;
                    if (drop_done && (pass_q < 4'(MAX_CASCADE))) begin
                        pass_d  = pass_q + 4'd1;
                        state_d = ST_SCAN;
                    end else begin
                        if (!drop_done) begin
                            err_d = 1'b1;
                        end
                        if (last_action) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + 4'd1;
                            state_d = ST_FETCH;
                        end
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_DONE: begin
                out_valid = 1'b1;
                out_score = score_q;
                state_d   = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cc_action_sequencer.sv
// tb/tb_cc_action_sequencer.sv - directed self-checking bench for cc_action_sequencer
module tb_cc_action_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] num_actions;
    logic [3:0] act_rd_addr;
    logic [1:0] act_type;
    logic [5:0] act_pos;
    logic       swap_en;
    logic [5:0] swap_pos_a, swap_pos_b;
    logic       scan_en;
    logic [2:0] scan_idx;
    logic [3:0] match_cnt;
    logic       clear_en, drop_en, drop_done;
    logic       busy, out_valid, err;
    logic [6:0] out_score;

    cc_action_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_actions (num_actions),
        .act_rd_addr (act_rd_addr),
        .act_type    (act_type),
        .act_pos     (act_pos),
        .swap_en     (swap_en),
        .swap_pos_a  (swap_pos_a),
        .swap_pos_b  (swap_pos_b),
        .scan_en     (scan_en),
        .scan_idx    (scan_idx),
        .match_cnt   (match_cnt),
        .clear_en    (clear_en),
        .drop_en     (drop_en),
        .drop_done   (drop_done),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_score   (out_score),
        .err         (err)
    );

    always #5 clk = ~clk;

    // action buffer model
    logic [1:0] tb_type [16];
    logic [5:0] tb_pos  [16];
    assign act_type = tb_type[act_rd_addr];
    assign act_pos  = tb_pos[act_rd_addr];

    // stimulus modes: 0 no matches, 1 scripted cascade, 2 eight every scan cycle
    int   mode;
    logic drop_never;
    assign drop_done = drop_never ? 1'b0 : drop_en;

    int cyc = 0;
    int n_swap = 0, n_scan = 0, n_clear = 0, n_drop = 0, n_valid = 0, seq_bad = 0;
    int swap_cyc = 0, scan0_cyc = 0, valid_cyc = 0, valid_score = 0;
    int swap_a = 0, swap_b = 0, scan_pos = 0;
    int base_swap, base_scan, base_clear, base_drop, base_valid, base_bad, t0_cyc;

    always_comb begin
        match_cnt = 4'd0;
        if (scan_en) begin
            if (mode == 2) begin
                match_cnt = 4'd8;
            end else if (mode == 1) begin
                if (n_clear - base_clear == 0) begin
                    if (scan_idx == 3'd1) match_cnt = 4'd2;
                    if (scan_idx == 3'd4) match_cnt = 4'd1;
                end else if (n_clear - base_clear == 1) begin
                    if (scan_idx == 3'd0) match_cnt = 4'd1;
                end
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (swap_en) begin
            n_swap   <= n_swap + 1;
            swap_cyc <= cyc;
            swap_a   <= int'(swap_pos_a);
            swap_b   <= int'(swap_pos_b);
        end
        if (scan_en) begin
            n_scan <= n_scan + 1;
            if (scan_idx == 3'd0) scan0_cyc <= cyc;
            if (int'(scan_idx) != scan_pos) seq_bad <= seq_bad + 1;
            scan_pos <= (scan_pos == 5) ? 0 : scan_pos + 1;
        end else begin
            scan_pos <= 0;
        end
        if (clear_en) n_clear <= n_clear + 1;
        if (drop_en)  n_drop  <= n_drop + 1;
        if (out_valid) begin
            n_valid     <= n_valid + 1;
            valid_cyc   <= cyc;
            valid_score <= int'(out_score);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic snapshot();
        base_swap  = n_swap;
        base_scan  = n_scan;
        base_clear = n_clear;
        base_drop  = n_drop;
        base_valid = n_valid;
        base_bad   = seq_bad;
    endtask

    task automatic run_round(input string tag, input logic [3:0] n, input int limit);
        int k;
        @(negedge clk);
        snapshot();
        start       = 1'b1;
        num_actions = n;
        t0_cyc      = cyc;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (n_valid == base_valid && k < limit) begin
            @(posedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, int'(n_valid != base_valid), 1);
        repeat (3) @(posedge clk);
        chk({tag, "_valid_once"}, n_valid - base_valid, 1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_actions = 4'd0;
        mode        = 0;
        drop_never  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tb_type[i] = 2'd3;
            tb_pos[i]  = 6'h00;
        end

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cmds", int'({swap_en, scan_en, clear_en, drop_en}), 0);
        chk("rst_addr", int'(act_rd_addr), 0);
        rst = 1'b0;

        // single Right at 0x00, no matches
        tb_type[0] = 2'd3; tb_pos[0] = 6'h00;
        run_round("single", 4'd1, 40);
        chk("single_swap_t", swap_cyc - t0_cyc, 2);
        chk("single_swap_a", swap_a, 6'h00);
        chk("single_swap_b", swap_b, 6'h01);
        chk("single_scan0_t", scan0_cyc - t0_cyc, 3);
        chk("single_scans", n_scan - base_scan, 6);
        chk("single_scan_seq", seq_bad - base_bad, 0);
        chk("single_valid_t", valid_cyc - t0_cyc, 10);
        chk("single_score", valid_score, 0);
        chk("single_clears", n_clear - base_clear, 0);
        chk("single_busy_after", int'(busy), 0);
        chk("single_score_idle", int'(out_score), 0);

        // invalid Up at row 0
        tb_type[0] = 2'd0; tb_pos[0] = 6'h03;
        run_round("invalid", 4'd1, 40);
        chk("invalid_swaps", n_swap - base_swap, 0);
        chk("invalid_scans", n_scan - base_scan, 0);
        chk("invalid_valid_t", valid_cyc - t0_cyc, 2);
        chk("invalid_score", valid_score, 0);

        // cascade: pass sums 3, 1, 0
        mode = 1;
        tb_type[0] = 2'd3; tb_pos[0] = 6'h00;
        run_round("cascade", 4'd1, 100);
        chk("cascade_clears", n_clear - base_clear, 2);
        chk("cascade_drops", n_drop - base_drop, 2);
        chk("cascade_scans", n_scan - base_scan, 18);
        chk("cascade_score", valid_score, 4);
        chk("cascade_scan_seq", seq_bad - base_bad, 0);

        // saturation and cascade cap over two actions
        mode = 2;
        tb_type[0] = 2'd3; tb_pos[0] = 6'h00;
        tb_type[1] = 2'd1; tb_pos[1] = 6'h00;
        run_round("sat", 4'd2, 400);
        chk("sat_scans", n_scan - base_scan, 96);
        chk("sat_clears", n_clear - base_clear, 16);
        chk("sat_score", valid_score, 127);
        chk("sat_err", int'(err), 0);

        // drop timeout with action count clamp
        drop_never = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tb_type[i] = 2'd3;
            tb_pos[i]  = 6'h00;
        end
        run_round("tmo", 4'd15, 3000);
        chk("tmo_swaps", n_swap - base_swap, 10);
        chk("tmo_drops", n_drop - base_drop, 10);
        chk("tmo_err", int'(err), 1);
        chk("tmo_score", valid_score, 127);
        drop_never = 1'b0;

        // zero actions: straight to DONE, err cleared by the new start
        mode = 0;
        run_round("zero", 4'd0, 20);
        chk("zero_valid_t", valid_cyc - t0_cyc, 1);
        chk("zero_err", int'(err), 0);
        chk("zero_swaps", n_swap - base_swap, 0);

        // reset during SCAN aborts the round
        tb_type[0] = 2'd3; tb_pos[0] = 6'h00;
        @(negedge clk);
        snapshot();
        start = 1'b1; num_actions = 4'd1;
        @(negedge clk);
        start = 1'b0;
        begin
            int k = 0;
            while (n_scan == base_scan && k < 20) begin
                @(posedge clk);
                k++;
            end
        end
        chk("abort_scan_seen", int'(n_scan != base_scan), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_scan_en", int'(scan_en), 0);
        @(negedge clk);
        rst = 1'b0;
        snapshot();
        repeat (20) @(posedge clk);
        chk("abort_quiet", (n_swap - base_swap) + (n_scan - base_scan) + (n_clear - base_clear)
                           + (n_drop - base_drop) + (n_valid - base_valid), 0);

        run_round("after_rst", 4'd1, 40);
        chk("after_rst_valid_t", valid_cyc - t0_cyc, 10);
        chk("after_rst_score", valid_score, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
